streaming_axi_regbank: RTL
==========================

// Module: streaming_axi_regbank
// PURPOSE
//  Parametrised AXI-lite-style burst register slave for the streaming subsystem; generalises the fixed capture control map.
//  Holds CH_NUM read-capture and CH_NUM write-capture reset bits, NUM_RW 32-bit RW registers and NUM_RO 32-bit RO inputs.
//  Adds WSTRB byte enables, FIXED/INCR bursts, SLVERR on illegal access and registered read data.
//  Sits between the AXI interconnect and the streaming datapath (capture, DDR window, HDMI status).
// PARAMETERS
//  ID_WIDTH   4          AXI ID width
//  CH_NUM     16         capture channels, 1..32
//  NUM_RW     8          32-bit RW registers, 1..64
//  NUM_RO     4          32-bit RO registers, 0..64
//  RW_RST     '0         NUM_RW*32-bit reset image, register k = RW_RST[32k+:32]
// PORTS
//  clk                  in   1          clock; SLAVE_CLK = clk
//  rstn                 in   1          synchronous active-low reset; SLAVE_RSTN = rstn
//  rd_capture_rstn      out  CH_NUM     per-channel read-capture enable bits
//  wr_capture_rstn      out  CH_NUM     per-channel write-capture enable bits
//  rw_regs              out  NUM_RW*32  RW register image, reg k at [32k+:32]
//  ro_regs              in   NUM_RO*32  RO status inputs, sampled at read-beat load
//  SLAVE_WR_ADDR_*/WR_DATA_*/WR_BACK_*  AXI write channels (ID, ADDR[31:0], LEN[7:0], BURST[1:0], DATA[31:0], STRB[3:0], LAST, VALID/READY, RESP[1:0])
//  SLAVE_RD_ADDR_*/RD_BACK_ID/RD_DATA_* AXI read channels (ID, ADDR, LEN, BURST, DATA[31:0], RESP, LAST, VALID/READY)
// BEHAVIOUR
//  Word map (addr +1 per beat): [0,CH_NUM) rd ctrl bit0; [32,32+CH_NUM) wr ctrl bit0; [64,64+NUM_RW) RW; [128,128+NUM_RO) RO.
//  Reset (rstn=0 at edge): both FSMs IDLE, all VALIDs 0, capture bits 0, rw_regs=RW_RST, RESP/ID regs 0. Reset mid-burst aborts; no response issued.
//  ADDR_READY = rstn && state==IDLE (combinational from state).
//  Write FSM IDLE->DATA on AW handshake; DATA->RESP on W handshake with LAST; RESP->IDLE on B handshake. WLEN ignored; LAST ends burst.
//  WR_DATA_READY = state==DATA. Each W beat: bytes with STRB set written (ctrl bits use STRB[0]); RO/unmapped/STRB=0 writes dropped.
//  BURST 00 FIXED: address held; 01 INCR: addr+1 per beat (32-bit wrap); 10/11: beats accepted, nothing written.
//  BRESP = 2'b10 if any beat hit RO/unmapped or burst 1x, else 2'b00; error flag sticky per burst, cleared in IDLE.
//  Read FSM IDLE->DATA on AR handshake; RVALID rises the cycle after AR handshake (1-cycle latency).
//  RDATA/RRESP/RLAST registered; loaded on AR handshake and on every R handshake that is not LAST; held stable while RVALID&&!RREADY.
//  Back-to-back beats: RVALID stays high across consecutive handshakes. DATA->IDLE on handshake with RLAST; RLAST on beat LEN (LEN+1 beats).
//  Unmapped read/burst 1x: RDATA=32'hFFFF_FFFF, RRESP=2'b10 for that beat. Ctrl-bit reads return {31'b0,bit}.
//  Read and write in same cycle to same register: read beat returns pre-write value.
//  Read and write channels fully independent; both FSMs may be active concurrently.
// CONFIGURATION
//  STREAMING_REGBANK_WR_PULSE_EN defined: extra output wr_pulse[NUM_RW-1:0]; bit k high one cycle after a beat writes RW reg k with STRB!=0.
//  Without it: port absent, no pulse logic; register behaviour identical.
// STRUCTURE
//  Package streaming_regs_pkg: burst_e (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR, wr_st_e/rd_st_e, map base constants (0/32/64/128).
//  Sub-module streaming_axi_burst_addr: address latch + FIXED/INCR advance + illegal-burst flag; instanced once per channel.
// TESTING
//  Reset: hold rstn=0 3 cycles with RW_RST=32'h1234_5678 at reg0 -> rw_regs[31:0]=32'h1234_5678, all VALID 0, capture bits 0.
//  INCR write addr 64 LEN 3 data 1,2,3,4 STRB F -> regs 0..3 = 1..4, BRESP 00, one B beat with matching ID.
//  Write 32'hAABBCCDD STRB 4'b0101 to addr 64 over 0 -> reg0=32'h00BB00DD; write addr 128 -> BRESP 10, RO unchanged.
//  INCR read addr 0 LEN 1 with RREADY low 5 cycles -> RDATA stable, RVALID held; then beats bit0/bit1, RLAST on 2nd.
//  Read burst 2'b10 or addr 200 -> RDATA FFFF_FFFF, RRESP 10 every beat; WRAP write -> no update, BRESP 10.
//  rstn low mid 4-beat write after beat 2 -> beats 1-2 kept, FSM IDLE, no B; next AW accepted first cycle after release.

Source files
------------

// File: rtl/streaming_regs_pkg.sv
// Shared types and constants for the streaming AXI-lite burst register bank.
package streaming_regs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;

  // Word-address bases of the four register windows.
  localparam int unsigned RD_CTRL_BASE = 0;
  localparam int unsigned WR_CTRL_BASE = 32;
  localparam int unsigned RW_BASE      = 64;
  localparam int unsigned RO_BASE      = 128;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_DATA = 2'b01,
    WR_RESP = 2'b10
  } wr_st_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_st_e;

  // Registered read-beat payload presented on the R channel.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rd_beat_t;

endpackage

// File: rtl/streaming_axi_regbank_if.sv
// AXI-lite-style burst bus between interconnect (master) and register bank (slave).
interface streaming_axi_regbank_if #(
  parameter int unsigned ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] WR_ADDR_ID;
  logic [31:0]         WR_ADDR;
  logic [7:0]          WR_ADDR_LEN;
  logic [1:0]          WR_ADDR_BURST;
  logic                WR_ADDR_VALID;
  logic                WR_ADDR_READY;
  logic [31:0]         WR_DATA;
  logic [3:0]          WR_DATA_STRB;
  logic                WR_DATA_LAST;
  logic                WR_DATA_VALID;
  logic                WR_DATA_READY;
  logic [ID_WIDTH-1:0] WR_BACK_ID;
  logic [1:0]          WR_BACK_RESP;
  logic                WR_BACK_VALID;
  logic                WR_BACK_READY;
  logic [ID_WIDTH-1:0] RD_ADDR_ID;
  logic [31:0]         RD_ADDR;
  logic [7:0]          RD_ADDR_LEN;
  logic [1:0]          RD_ADDR_BURST;
  logic                RD_ADDR_VALID;
  logic                RD_ADDR_READY;
  logic [ID_WIDTH-1:0] RD_BACK_ID;
  logic [31:0]         RD_DATA;
  logic [1:0]          RD_DATA_RESP;
  logic                RD_DATA_LAST;
  logic                RD_DATA_VALID;
  logic                RD_DATA_READY;

  modport master (
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_ADDR_READY,
    output WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
    input  WR_DATA_READY,
    input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    output WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    input  RD_ADDR_READY,
    input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    output RD_DATA_READY
  );

  modport slave (
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_ADDR_READY,
    input  WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
    output WR_DATA_READY,
    output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    input  WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );
endinterface

// File: rtl/streaming_axi_burst_addr.sv
// Burst address tracker: latches the start address, advances for INCR, flags burst types 1x.
module streaming_axi_burst_addr
  import streaming_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        burst_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              illegal_o,
  output logic [ADDR_W-1:0] addr_nxt_c,
  output logic              illegal_nxt_c
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        burst_q, burst_d;

  // Next address: new burst start on load, +1 (32-bit wrap) per beat for INCR.
  always_comb begin
    addr_d  = addr_q;
    burst_d = burst_q;
    if (load_i) begin
      addr_d  = addr_i;
      burst_d = burst_i;
    end else if (advance_i && (burst_q == BURST_INCR)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Address/burst register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q  <= '0;
      burst_q <= '0;
    end else begin
      addr_q  <= addr_d;
      burst_q <= burst_d;
    end
  end

  assign addr_o        = addr_q;
  assign illegal_o     = burst_q[1];
  assign addr_nxt_c    = addr_d;
  assign illegal_nxt_c = burst_d[1];

endmodule

// File: rtl/streaming_axi_regbank.sv
// Parametrised AXI-lite-style burst register slave for the streaming subsystem.
// Optional feature: define STREAMING_REGBANK_WR_PULSE_EN to add the wr_pulse output.
module streaming_axi_regbank
  import streaming_regs_pkg::*;
#(
  parameter int unsigned           ID_WIDTH = 4,
  parameter int unsigned           CH_NUM   = 16,
  parameter int unsigned           NUM_RW   = 8,
  parameter int unsigned           NUM_RO   = 4,
  parameter logic [NUM_RW*32-1:0]  RW_RST   = '0
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  streaming_axi_regbank_if.slave                    slave,
  output logic [CH_NUM-1:0]                         rd_capture_rstn,
  output logic [CH_NUM-1:0]                         wr_capture_rstn,
  output logic [NUM_RW*32-1:0]                      rw_regs,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_regs
`ifdef STREAMING_REGBANK_WR_PULSE_EN
  ,
  output logic [NUM_RW-1:0]                         wr_pulse
`endif
);

  wr_st_e wr_st_q, wr_st_d;
  rd_st_e rd_st_q, rd_st_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [CH_NUM-1:0]   rd_cap_q, rd_cap_d, wr_cap_q, wr_cap_d;
  logic [NUM_RW*32-1:0] rw_q, rw_d;
  logic [ID_WIDTH-1:0] wr_id_q, wr_id_d, rd_id_q, rd_id_d;
  logic                wr_err_q, wr_err_d, wr_hit, wr_beat_err, wr_en;
  logic [1:0]          wr_resp_q, wr_resp_d;
  logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d, rd_len_q, rd_len_d;
  rd_beat_t            rd_beat_q, rd_beat_d;
  logic                rd_load, rd_hit, rd_last;
  logic [DATA_W-1:0]   rd_word;

  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt;
  logic              wr_ill, wr_ill_nxt, rd_ill, rd_ill_nxt;
  logic              unused_ok;

  assign aw_hs = slave.WR_ADDR_VALID && rstn && (wr_st_q == WR_IDLE);
  assign w_hs  = slave.WR_DATA_VALID && (wr_st_q == WR_DATA);
  assign b_hs  = slave.WR_BACK_READY && (wr_st_q == WR_RESP);
  assign ar_hs = slave.RD_ADDR_VALID && rstn && (rd_st_q == RD_IDLE);
  assign r_hs  = slave.RD_DATA_READY && (rd_st_q == RD_DATA);
  assign rd_load = ar_hs || (r_hs && !rd_beat_q.last);

  streaming_axi_burst_addr u_wr_addr (
    .clk(clk), .rstn(rstn), .load_i(aw_hs), .addr_i(slave.WR_ADDR),
    .burst_i(slave.WR_ADDR_BURST), .advance_i(w_hs), .addr_o(wr_addr),
    .illegal_o(wr_ill), .addr_nxt_c(wr_addr_nxt), .illegal_nxt_c(wr_ill_nxt)
  );

  streaming_axi_burst_addr u_rd_addr (
    .clk(clk), .rstn(rstn), .load_i(ar_hs), .addr_i(slave.RD_ADDR),
    .burst_i(slave.RD_ADDR_BURST), .advance_i(r_hs && !rd_beat_q.last), .addr_o(rd_addr),
    .illegal_o(rd_ill), .addr_nxt_c(rd_addr_nxt), .illegal_nxt_c(rd_ill_nxt)
  );

  // Write FSM next state: LAST ends the burst, WLEN is not consulted.
  always_comb begin
    wr_st_d = wr_st_q;
    case (wr_st_q)
      WR_IDLE: if (aw_hs) wr_st_d = WR_DATA;
      WR_DATA: if (w_hs && slave.WR_DATA_LAST) wr_st_d = WR_RESP;
      WR_RESP: if (b_hs) wr_st_d = WR_IDLE;
      default: wr_st_d = WR_IDLE;
    endcase
  end

  // Read FSM next state: leaves DATA on the handshake of the LAST beat.
  always_comb begin
    rd_st_d = rd_st_q;
    case (rd_st_q)
      RD_IDLE: if (ar_hs) rd_st_d = RD_DATA;
      RD_DATA: if (r_hs && rd_beat_q.last) rd_st_d = RD_IDLE;
      default: rd_st_d = RD_IDLE;
    endcase
  end

  // Write-beat decode: byte-enabled RW update, ctrl bits on STRB[0], sticky error tracking.
  always_comb begin
    rd_cap_d = rd_cap_q;
    wr_cap_d = wr_cap_q;
    rw_d     = rw_q;
    wr_hit   = 1'b0;
    wr_en    = w_hs && !wr_ill;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      if (wr_addr == ADDR_W'(RD_CTRL_BASE) + ADDR_W'(k)) begin
        wr_hit = 1'b1;
        if (wr_en && slave.WR_DATA_STRB[0]) rd_cap_d[k] = slave.WR_DATA[0];
      end
      if (wr_addr == ADDR_W'(WR_CTRL_BASE) + ADDR_W'(k)) begin
        wr_hit = 1'b1;
        if (wr_en && slave.WR_DATA_STRB[0]) wr_cap_d[k] = slave.WR_DATA[0];
      end
    end
    for (int k = 0; k < int'(NUM_RW); k++) begin
      if (wr_addr == ADDR_W'(RW_BASE) + ADDR_W'(k)) begin
        wr_hit = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (wr_en && slave.WR_DATA_STRB[b]) rw_d[32*k+8*b +: 8] = slave.WR_DATA[8*b +: 8];
        end
      end
    end
    wr_beat_err = wr_ill || !wr_hit;
    wr_err_d    = (wr_st_q == WR_IDLE) ? 1'b0 : (wr_err_q || (w_hs && wr_beat_err));
    wr_resp_d   = wr_resp_q;
    if (w_hs && slave.WR_DATA_LAST) wr_resp_d = (wr_err_q || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
    wr_id_d     = aw_hs ? slave.WR_ADDR_ID : wr_id_q;
  end

  // Read-beat lookup at the address of the beat being loaded; sees pre-write register values.
  always_comb begin
    rd_word = 32'hFFFF_FFFF;
    rd_hit  = 1'b0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      if (rd_addr_nxt == ADDR_W'(RD_CTRL_BASE) + ADDR_W'(k)) begin
        rd_hit = 1'b1; rd_word = {31'b0, rd_cap_q[k]};
      end
      if (rd_addr_nxt == ADDR_W'(WR_CTRL_BASE) + ADDR_W'(k)) begin
        rd_hit = 1'b1; rd_word = {31'b0, wr_cap_q[k]};
      end
    end
    for (int k = 0; k < int'(NUM_RW); k++) begin
      if (rd_addr_nxt == ADDR_W'(RW_BASE) + ADDR_W'(k)) begin
        rd_hit = 1'b1; rd_word = rw_q[32*k +: 32];
      end
    end
    for (int k = 0; k < int'(NUM_RO); k++) begin
      if (rd_addr_nxt == ADDR_W'(RO_BASE) + ADDR_W'(k)) begin
        rd_hit = 1'b1; rd_word = ro_regs[32*k +: 32];
      end
    end
    rd_last  = ar_hs ? (slave.RD_ADDR_LEN == '0) : (LEN_W'(rd_cnt_q + LEN_W'(1)) == rd_len_q);
    rd_cnt_d = ar_hs ? '0 : (rd_load ? LEN_W'(rd_cnt_q + LEN_W'(1)) : rd_cnt_q);
    rd_len_d = ar_hs ? slave.RD_ADDR_LEN : rd_len_q;
    rd_id_d  = ar_hs ? slave.RD_ADDR_ID : rd_id_q;
    rd_beat_d = rd_beat_q;
    if (rd_load) begin
      rd_beat_d.data = (rd_ill_nxt || !rd_hit) ? 32'hFFFF_FFFF : rd_word;
      rd_beat_d.resp = (rd_ill_nxt || !rd_hit) ? RESP_SLVERR : RESP_OKAY;
      rd_beat_d.last = rd_last;
    end
  end

  // State and datapath registers; reset aborts any burst without a response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_st_q   <= WR_IDLE;
      rd_st_q   <= RD_IDLE;
      rd_cap_q  <= '0;
      wr_cap_q  <= '0;
      rw_q      <= RW_RST;
      wr_id_q   <= '0;
      wr_err_q  <= 1'b0;
      wr_resp_q <= RESP_OKAY;
      rd_id_q   <= '0;
      rd_cnt_q  <= '0;
      rd_len_q  <= '0;
      rd_beat_q <= '0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      rd_cap_q  <= rd_cap_d;
      wr_cap_q  <= wr_cap_d;
      rw_q      <= rw_d;
      wr_id_q   <= wr_id_d;
      wr_err_q  <= wr_err_d;
      wr_resp_q <= wr_resp_d;
      rd_id_q   <= rd_id_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_len_q  <= rd_len_d;
      rd_beat_q <= rd_beat_d;
    end
  end

`ifdef STREAMING_REGBANK_WR_PULSE_EN
  logic [NUM_RW-1:0] pulse_q, pulse_d;

  // One-cycle strobe per RW register written by a beat with any byte enabled.
  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < int'(NUM_RW); k++) begin
      if (wr_en && (|slave.WR_DATA_STRB) && (wr_addr == ADDR_W'(RW_BASE) + ADDR_W'(k))) pulse_d[k] = 1'b1;
    end
  end

  // Pulse register.
  always_ff @(posedge clk) begin
    if (!rstn) pulse_q <= '0;
    else       pulse_q <= pulse_d;
  end

  assign wr_pulse = pulse_q;
`endif

  assign slave.WR_ADDR_READY = rstn && (wr_st_q == WR_IDLE);
  assign slave.WR_DATA_READY = (wr_st_q == WR_DATA);
  assign slave.WR_BACK_VALID = (wr_st_q == WR_RESP);
  assign slave.WR_BACK_ID    = wr_id_q;
  assign slave.WR_BACK_RESP  = wr_resp_q;
  assign slave.RD_ADDR_READY = rstn && (rd_st_q == RD_IDLE);
  assign slave.RD_DATA_VALID = (rd_st_q == RD_DATA);
  assign slave.RD_BACK_ID    = rd_id_q;
  assign slave.RD_DATA       = rd_beat_q.data;
  assign slave.RD_DATA_RESP  = rd_beat_q.resp;
  assign slave.RD_DATA_LAST  = rd_beat_q.last;

  assign rd_capture_rstn = rd_cap_q;
  assign wr_capture_rstn = wr_cap_q;
  assign rw_regs         = rw_q;

  assign unused_ok = ^{wr_addr_nxt, wr_ill_nxt, rd_addr, rd_ill, slave.WR_ADDR_LEN};

endmodule
